// File: rtl/counter_cmd_seq.sv
// Command sequencer for an up/down counter: accepts LOAD / count-N commands over
// valid/ready and drives the counter's load_n, up_down, ce and data_load inputs.
module counter_cmd_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_sat,
    input  logic             max_count,
    input  logic             zero,
    output logic             load_n,
    output logic             up_down,
    output logic             ce,
    output logic [WIDTH-1:0] data_load,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] steps_done,
    output logic             sat_hit
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;

    state_t           state, state_next;
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] remaining;
    logic             sat;
    logic             accept;
    logic             limit;
    logic             stop;

    // Handshake: a command transfers on a posedge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE and never while rst_n is low.
    assign cmd_ready = (state == IDLE) && rst_n;
    assign accept    = cmd_valid && cmd_ready;

    // The counter flags reflect the value the next ce would move away from,
    // so stopping on them never overshoots the limit.
    assign limit = (op == OP_UP) ? max_count : zero;
    assign stop  = sat && limit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            op         <= '0;
            data       <= '0;
            sat        <= 1'b0;
            remaining  <= '0;
            steps_done <= '0;
            sat_hit    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op         <= cmd_op;
                data       <= cmd_data;
                sat        <= cmd_sat;
                remaining  <= cmd_data;
                steps_done <= '0;
                sat_hit    <= 1'b0;
            end else if (state == RUN) begin
                if (stop) begin
                    sat_hit <= 1'b1;
                end else begin
                    remaining  <= remaining - WIDTH'(1);
                    steps_done <= steps_done + WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD:        state_next = LOAD;
                        OP_UP, OP_DOWN: state_next = (cmd_data != '0) ? RUN : DONE;
                        default:        state_next = DONE;
                    endcase
                end
            end
            LOAD:    state_next = DONE;
            RUN:     if (stop || remaining == WIDTH'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter controls depend only on state and captured fields; gating with
    // rst_n keeps the counter quiet for the whole reset window.
    always_comb begin
        load_n    = 1'b1;
        ce        = 1'b0;
        up_down   = 1'b1;
        data_load = '0;
        busy      = 1'b0;
        done      = 1'b0;
        if (rst_n) begin
            case (state)
                LOAD: begin
                    load_n    = 1'b0;
                    data_load = data;
                    busy      = 1'b1;
                end
                RUN: begin
                    busy    = 1'b1;
                    up_down = (op == OP_UP);
                    ce      = !stop;
                end
                DONE:    done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Bench for counter_cmd_seq with a behavioural up/down counter downstream;
// table-driven command vectors plus hand-written reset and ignore sequences.
module tb_counter_cmd_seq;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic       cmd_sat;
    logic       max_count;
    logic       zero;
    logic       load_n;
    logic       up_down;
    logic       ce;
    logic [3:0] data_load;
    logic       busy;
    logic       done;
    logic [3:0] steps_done;
    logic       sat_hit;
    logic [3:0] count_out;

    int total = 0;
    int bad   = 0;

    counter_cmd_seq #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_sat    (cmd_sat),
        .max_count  (max_count),
        .zero       (zero),
        .load_n     (load_n),
        .up_down    (up_down),
        .ce         (ce),
        .data_load  (data_load),
        .busy       (busy),
        .done       (done),
        .steps_done (steps_done),
        .sat_hit    (sat_hit)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream registered up/down counter sharing the reset net
    always_ff @(posedge clk) begin
        if (!rst_n)       count_out <= 4'd0;
        else if (!load_n) count_out <= data_load;
        else if (ce)      count_out <= up_down ? count_out + 4'd1 : count_out - 4'd1;
    end
    assign max_count = (count_out == 4'hF);
    assign zero      = (count_out == 4'h0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        logic       sat;
        int         exp_lat;
        int         exp_ces;
        int         exp_loads;
        logic [3:0] exp_count;
        logic [3:0] exp_steps;
        logic       exp_sat_hit;
    } vec_t;

    vec_t vecs[14];

    // Driver: issue one command, watch it to completion, check protocol and results.
    task automatic do_cmd(input int idx, input logic [1:0] op, input logic [3:0] d,
                          input logic s, output int lat, output int ces,
                          output int loads, output logic [3:0] load_val);
        int guard;
        int dir_err;
        int overlap;
        int dones;
        lat = 0; ces = 0; loads = 0; load_val = 4'd0;
        dir_err = 0; overlap = 0; dones = 0; guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_sat = s;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("v%0d_ready_before", idx), cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = 4'd0; cmd_sat = 1'b0;
        while (dones == 0 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ce) begin
                ces++;
                if (up_down !== (op == OP_UP)) dir_err++;
            end
            if (!load_n) begin
                loads++;
                load_val = data_load;
            end
            if (!load_n && ce) overlap++;
            if (done) dones++;
            else if (cmd_ready) guard = 100;
        end
        chk($sformatf("v%0d_done_seen", idx), dones, 1);
        chk($sformatf("v%0d_dir", idx), dir_err, 0);
        chk($sformatf("v%0d_load_ce_overlap", idx), overlap, 0);
        chk($sformatf("v%0d_no_early_ready", idx), guard == 100, 0);
        @(negedge clk);
        chk($sformatf("v%0d_done_one_cycle", idx), done, 0);
        chk($sformatf("v%0d_ready_after", idx), cmd_ready, 1);
    endtask

    initial begin
        int         lat;
        int         ces;
        int         loads;
        int         n;
        int         guard;
        int         dones;
        logic [3:0] load_val;

        vecs[0]  = '{OP_LOAD, 4'd9,  1'b0, 2,  0,  1, 4'd9,  4'd0,  1'b0};
        vecs[1]  = '{OP_UP,   4'd3,  1'b0, 4,  3,  0, 4'd12, 4'd3,  1'b0};
        vecs[2]  = '{OP_UP,   4'd10, 1'b1, 5,  3,  0, 4'd15, 4'd3,  1'b1};
        vecs[3]  = '{OP_LOAD, 4'd12, 1'b0, 2,  0,  1, 4'd12, 4'd0,  1'b0};
        vecs[4]  = '{OP_UP,   4'd10, 1'b0, 11, 10, 0, 4'd6,  4'd10, 1'b0};
        vecs[5]  = '{OP_DOWN, 4'd0,  1'b0, 1,  0,  0, 4'd6,  4'd0,  1'b0};
        vecs[6]  = '{OP_NOP,  4'd5,  1'b1, 1,  0,  0, 4'd6,  4'd0,  1'b0};
        vecs[7]  = '{OP_LOAD, 4'd1,  1'b0, 2,  0,  1, 4'd1,  4'd0,  1'b0};
        vecs[8]  = '{OP_DOWN, 4'd5,  1'b1, 3,  1,  0, 4'd0,  4'd1,  1'b1};
        vecs[9]  = '{OP_DOWN, 4'd3,  1'b0, 4,  3,  0, 4'd13, 4'd3,  1'b0};
        vecs[10] = '{OP_UP,   4'd15, 1'b0, 16, 15, 0, 4'd12, 4'd15, 1'b0};
        vecs[11] = '{OP_LOAD, 4'd15, 1'b0, 2,  0,  1, 4'd15, 4'd0,  1'b0};
        vecs[12] = '{OP_UP,   4'd4,  1'b1, 2,  0,  0, 4'd15, 4'd0,  1'b1};
        vecs[13] = '{OP_DOWN, 4'd2,  1'b1, 3,  2,  0, 4'd13, 4'd2,  1'b0};

        // Reset with a command waiting: it must not be accepted
        rst_n = 1'b0;
        cmd_valid = 1'b1; cmd_op = OP_UP; cmd_data = 4'd5; cmd_sat = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_ce", ce, 0);
        chk("rst_load_n", load_n, 1);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        chk("rst2_cmd_ready", cmd_ready, 0);
        rst_n = 1'b1;
        cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = 4'd0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_done", done, 0);
        chk("post_rst_steps", steps_done, 0);
        chk("post_rst_count", count_out, 0);
        chk("post_rst_zero", zero, 1);

        // Table-driven command vectors
        for (int i = 0; i < 14; i++) begin
            do_cmd(i, vecs[i].op, vecs[i].data, vecs[i].sat, lat, ces, loads, load_val);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_ce_pulses", i), ces, vecs[i].exp_ces);
            chk($sformatf("v%0d_load_pulses", i), loads, vecs[i].exp_loads);
            if (vecs[i].exp_loads > 0)
                chk($sformatf("v%0d_data_load", i), load_val, vecs[i].data);
            chk($sformatf("v%0d_count", i), count_out, vecs[i].exp_count);
            chk($sformatf("v%0d_steps_done", i), steps_done, vecs[i].exp_steps);
            chk($sformatf("v%0d_sat_hit", i), sat_hit, vecs[i].exp_sat_hit);
        end

        // Commands presented while busy are ignored: UP 4 from 13, then LOAD 7 held high
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_UP; cmd_data = 4'd4; cmd_sat = 1'b0;
        @(posedge clk);
        #1;
        cmd_op = OP_LOAD; cmd_data = 4'd7;
        loads = 0; dones = 0; guard = 0;
        while (dones == 0 && guard < 20) begin
            @(negedge clk);
            guard++;
            if (!load_n) loads++;
            if (done) dones++;
        end
        cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = 4'd0;
        chk("busy_ign_done", dones, 1);
        chk("busy_ign_loads", loads, 0);
        chk("busy_ign_count", count_out, 1);
        chk("busy_ign_steps", steps_done, 4);
        @(negedge clk);
        chk("busy_ign_ready", cmd_ready, 1);

        // Reset in the middle of DOWN 8 from 15
        do_cmd(20, OP_LOAD, 4'd15, 1'b0, lat, ces, loads, load_val);
        chk("midrst_start_count", count_out, 15);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_DOWN; cmd_data = 4'd8; cmd_sat = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = 4'd0;
        n = 0; guard = 0;
        while (n < 2 && guard < 20) begin
            @(negedge clk);
            guard++;
            if (ce) n++;
        end
        chk("midrst_ce_pulses", n, 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ce", ce, 0);
        chk("midrst_done", done, 0);
        chk("midrst_steps", steps_done, 0);
        chk("midrst_sat_hit", sat_hit, 0);
        chk("midrst_count", count_out, 0);
        chk("midrst_ready_low", cmd_ready, 0);
        rst_n = 1'b1;
        dones = 0;
        @(negedge clk);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_busy", busy, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || ce) dones++;
        end
        chk("midrst_quiet", dones, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
